frame_scan_reader: RTL



---
 rtl/frame_scan_reader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/frame_scan_reader.sv
// Port-B frame reader: sweeps FRAME_W x FRAME_H pixels from ROM or RAM and streams them out in raster order.
// Optional FRAME_SCAN_CHECKSUM_EN adds a running modulo-2^24 pixel checksum output.
module frame_scan_reader #(
    parameter int FRAME_W      = 300,
    parameter int FRAME_H      = 300,
    parameter int ROM_BASE     = 0,
    parameter int RAM_BASE     = 90300,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        src_sel,
    output logic [17:0] address_b,
    input  logic [23:0] read_data_b,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_last,
    output logic        busy,
    output logic        frame_done
`ifdef FRAME_SCAN_CHECKSUM_EN
    ,
    output logic [23:0] checksum
`endif
);

    localparam int NPIX  = FRAME_W * FRAME_H;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [17:0] ROM_A = 18'(ROM_BASE);
    localparam logic [17:0] RAM_A = 18'(RAM_BASE);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t              state;
    logic [17:0]         base_r;
    logic [16:0]         issue_count;
    logic [READ_LATENCY:0] vld_p;
    logic [23:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;
    logic                pop;
    logic                push;
    logic                start_acc;
    logic                issue;
    logic                issue_now;
    int                  occupancy;

    function automatic int count_tokens(input logic [READ_LATENCY:0] v);
        int c;
        c = 0;
        for (int i = 0; i <= READ_LATENCY; i++)
            if (v[i]) c++;
        return c;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pix_valid = (fifo_count != '0);
    assign pix_data  = pix_valid ? fifo_mem[rd_ptr] : '0;
    assign pix_last  = pix_valid && (pix_x == 9'(FRAME_W - 1)) && (pix_y == 9'(FRAME_H - 1));
    assign pop       = pix_valid & pix_ready;
    // The token leaving the last stage lines up with the memory's registered output.
    assign push      = vld_p[READ_LATENCY];

    // A pop this cycle frees a slot, which keeps a full-rate stream free of bubbles.
    always_comb begin
        occupancy = count_tokens(vld_p) + int'(fifo_count) - (pop ? 1 : 0);
        start_acc = (state == IDLE) && start && !busy;
        issue     = (state == SCAN) && (occupancy < FIFO_DEPTH);
        issue_now = issue | start_acc;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= read_data_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            base_r      <= '0;
            issue_count <= '0;
            vld_p       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            address_b   <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
`ifdef FRAME_SCAN_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (frame_done) busy <= 1'b0;
            vld_p      <= {vld_p[READ_LATENCY-1:0], issue_now};
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
                if (pix_x == 9'(FRAME_W - 1)) begin
                    pix_x <= '0;
                    pix_y <= (pix_y == 9'(FRAME_H - 1)) ? '0 : pix_y + 1'b1;
                end else begin
                    pix_x <= pix_x + 1'b1;
                end
            end
`ifdef FRAME_SCAN_CHECKSUM_EN
            if (start_acc)  checksum <= '0;
            else if (pop)   checksum <= checksum + pix_data;
`endif
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        base_r      <= src_sel ? RAM_A : ROM_A;
                        address_b   <= src_sel ? RAM_A : ROM_A;
                        issue_count <= 17'd1;
                        busy        <= 1'b1;
                        pix_x       <= '0;
                        pix_y       <= '0;
                        state       <= (NPIX == 1) ? DRAIN : SCAN;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        address_b   <= base_r + {1'b0, issue_count};
                        issue_count <= issue_count + 1'b1;
                        if (issue_count == 17'(NPIX - 1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && pix_last) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
